// File: rtl/id_stage_pipe.sv
// RV32I decode stage: decodes OP-IMM/OP/LUI/AUIPC, resolves operands through a
// prioritised forwarding network, and registers results into an ID/EX slot.
module id_stage_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NFWD    = 2,
    parameter int unsigned STALL_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          inst_i,
    output logic                 reg1_read_o,
    output logic                 reg2_read_o,
    output logic [4:0]           reg1_addr_o,
    output logic [4:0]           reg2_addr_o,
    input  logic [XLEN-1:0]      reg1_data_i,
    input  logic [XLEN-1:0]      reg2_data_i,
    input  logic [NFWD-1:0]      fwd_wreg_i,
    input  logic [5*NFWD-1:0]    fwd_wd_i,
    input  logic [XLEN*NFWD-1:0] fwd_wdata_i,
    input  logic [NFWD-1:0]      fwd_pend_i,
    input  logic                 flush_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           aluop_o,
    output logic [2:0]           alusel_o,
    output logic [XLEN-1:0]      reg1_o,
    output logic [XLEN-1:0]      reg2_o,
    output logic [4:0]           wd_o,
    output logic                 wreg_o,
    output logic [XLEN-1:0]      pc_o,
    output logic                 illegal_o,
    output logic [STALL_W-1:0]   stall_cnt_o
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;
    localparam logic [7:0] EXE_SUB_OP  = 8'b00100010;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [7:0]      w_aluop;
    logic [2:0]      w_alusel;
    logic            w_wreg;
    logic            w_illegal;
    logic            w_re1;
    logic            w_re2;
    logic            w_use_imm;
    logic            w_use_pc;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;
    logic            w_pend1;
    logic            w_pend2;
    logic            w_hazard;
    logic            w_capture;

    logic               r_valid;
    logic [7:0]         r_aluop;
    logic [2:0]         r_alusel;
    logic [XLEN-1:0]    r_reg1;
    logic [XLEN-1:0]    r_reg2;
    logic [4:0]         r_wd;
    logic               r_wreg;
    logic [XLEN-1:0]    r_pc;
    logic               r_illegal;
    logic [STALL_W-1:0] r_stall;

    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];

    // Instruction decode; illegal encodings collapse to a NOP that reads nothing.
    always_comb begin
        w_aluop   = EXE_NOP_OP;
        w_alusel  = EXE_RES_NOP;
        w_wreg    = 1'b0;
        w_illegal = 1'b0;
        w_re1     = 1'b0;
        w_re2     = 1'b0;
        w_use_imm = 1'b0;
        w_use_pc  = 1'b0;
        w_imm     = '0;
        case (w_opcode)
            OPC_OP_IMM: begin
                w_re1     = 1'b1;
                w_wreg    = 1'b1;
                w_use_imm = 1'b1;
                w_imm     = XLEN'($signed(inst_i[31:20]));
                case (w_funct3)
                    3'b000: begin w_aluop = EXE_ADD_OP;  w_alusel = EXE_RES_ARITH; end
                    3'b010: begin w_aluop = EXE_SLT_OP;  w_alusel = EXE_RES_ARITH; end
                    3'b011: begin w_aluop = EXE_SLTU_OP; w_alusel = EXE_RES_ARITH; end
                    3'b100: begin w_aluop = EXE_XOR_OP;  w_alusel = EXE_RES_LOGIC; end
                    3'b110: begin w_aluop = EXE_OR_OP;   w_alusel = EXE_RES_LOGIC; end
                    3'b111: begin w_aluop = EXE_AND_OP;  w_alusel = EXE_RES_LOGIC; end
                    3'b001: begin
                        w_imm    = XLEN'(inst_i[24:20]);
                        w_aluop  = EXE_SLL_OP;
                        w_alusel = EXE_RES_SHIFT;
                        w_illegal = (w_funct7 != 7'b0000000);
                    end
                    default: begin
                        w_imm    = XLEN'(inst_i[24:20]);
                        w_aluop  = w_funct7[5] ? EXE_SRA_OP : EXE_SRL_OP;
                        w_alusel = EXE_RES_SHIFT;
                        w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                w_re1  = 1'b1;
                w_re2  = 1'b1;
                w_wreg = 1'b1;
                case (w_funct3)
                    3'b000: begin w_aluop = w_funct7[5] ? EXE_SUB_OP : EXE_ADD_OP; w_alusel = EXE_RES_ARITH; end
                    3'b001: begin w_aluop = EXE_SLL_OP;  w_alusel = EXE_RES_SHIFT; end
                    3'b010: begin w_aluop = EXE_SLT_OP;  w_alusel = EXE_RES_ARITH; end
                    3'b011: begin w_aluop = EXE_SLTU_OP; w_alusel = EXE_RES_ARITH; end
                    3'b100: begin w_aluop = EXE_XOR_OP;  w_alusel = EXE_RES_LOGIC; end
                    3'b101: begin w_aluop = w_funct7[5] ? EXE_SRA_OP : EXE_SRL_OP; w_alusel = EXE_RES_SHIFT; end
                    3'b110: begin w_aluop = EXE_OR_OP;   w_alusel = EXE_RES_LOGIC; end
                    default: begin w_aluop = EXE_AND_OP; w_alusel = EXE_RES_LOGIC; end
                endcase
                // funct7[5] is only meaningful for SUB and SRA
                w_illegal = !((w_funct7 == 7'b0000000) ||
                              (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
            end
            OPC_LUI: begin
                w_wreg    = 1'b1;
                w_use_imm = 1'b1;
                w_imm     = XLEN'($signed({inst_i[31:12], 12'h000}));
                w_aluop   = EXE_ADD_OP;
                w_alusel  = EXE_RES_ARITH;
            end
            OPC_AUIPC: begin
                w_wreg    = 1'b1;
                w_use_imm = 1'b1;
                w_use_pc  = 1'b1;
                w_imm     = XLEN'($signed({inst_i[31:12], 12'h000}));
                w_aluop   = EXE_ADD_OP;
                w_alusel  = EXE_RES_ARITH;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_aluop   = EXE_NOP_OP;
            w_alusel  = EXE_RES_NOP;
            w_wreg    = 1'b0;
            w_re1     = 1'b0;
            w_re2     = 1'b0;
            w_use_imm = 1'b0;
            w_use_pc  = 1'b0;
        end
    end

    // Forward select: descending scan so the lowest matching index wins; x0 never forwards.
    always_comb begin
        w_src1  = reg1_data_i;
        w_src2  = reg2_data_i;
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int i = int'(NFWD) - 1; i >= 0; i--) begin
            if (fwd_wreg_i[i] && fwd_wd_i[i*5 +: 5] == inst_i[19:15]) begin
                w_src1  = fwd_wdata_i[i*XLEN +: XLEN];
                w_pend1 = fwd_pend_i[i];
            end
            if (fwd_wreg_i[i] && fwd_wd_i[i*5 +: 5] == inst_i[24:20]) begin
                w_src2  = fwd_wdata_i[i*XLEN +: XLEN];
                w_pend2 = fwd_pend_i[i];
            end
        end
        if (inst_i[19:15] == 5'd0) begin
            w_src1  = '0;
            w_pend1 = 1'b0;
        end
        if (inst_i[24:20] == 5'd0) begin
            w_src2  = '0;
            w_pend2 = 1'b0;
        end
    end

    assign reg1_read_o = w_re1;
    assign reg2_read_o = w_re2;
    assign reg1_addr_o = inst_i[19:15];
    assign reg2_addr_o = inst_i[24:20];

    assign w_hazard  = in_valid && ((w_re1 && w_pend1) || (w_re2 && w_pend2));
    assign in_ready  = (!r_valid || out_ready) && !w_hazard;
    assign w_capture = in_valid && in_ready && !flush_i;

    // ID/EX register and saturating load-use stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_aluop   <= EXE_NOP_OP;
            r_alusel  <= EXE_RES_NOP;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_wd      <= '0;
            r_wreg    <= 1'b0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
            r_stall   <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid   <= 1'b1;
                r_aluop   <= w_aluop;
                r_alusel  <= w_alusel;
                r_reg1    <= w_use_pc ? pc_i : (w_re1 ? w_src1 : '0);
                r_reg2    <= w_use_imm ? w_imm : (w_re2 ? w_src2 : '0);
                r_wd      <= w_illegal ? 5'd0 : inst_i[11:7];
                r_wreg    <= w_wreg;
                r_pc      <= pc_i;
                r_illegal <= w_illegal;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_hazard && !flush_i && r_stall != '1) begin
                r_stall <= r_stall + STALL_W'(1);
            end
        end
    end

    assign out_valid   = r_valid;
    assign aluop_o     = r_aluop;
    assign alusel_o    = r_alusel;
    assign reg1_o      = r_reg1;
    assign reg2_o      = r_reg2;
    assign wd_o        = r_wd;
    assign wreg_o      = r_wreg;
    assign pc_o        = r_pc;
    assign illegal_o   = r_illegal;
    assign stall_cnt_o = r_stall;
endmodule
